// File: rtl/celement_branch_buf.sv
// Clocked multi-branch token buffer: four-phase input handshake into a FIFO,
// per-token branch-mask replay over independent four-phase output handshakes.
module celement_branch_buf #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned DW          = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SEND_DLY    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic           CLK,
    input  logic           RESETN,
    input  logic           LOPEN,
    input  logic           SENDIN,
    output logic           ACKOUT,
    input  logic [DW-1:0]  DATAIN,
    input  logic [NCH-1:0] EXBIN,
    output logic [NCH-1:0] SENDOUT,
    input  logic [NCH-1:0] ACKIN,
    output logic [DW-1:0]  DATAOUT,
    output logic           CP,
    output logic           DROP,
    output logic [CW-1:0]  COUNT
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned EW   = NCH + DW;
    localparam int unsigned DLYW = (SEND_DLY > 0) ? $clog2(SEND_DLY + 1) : 1;

    typedef enum logic {U_IDLE, U_ACK} u_state_e;
    typedef enum logic [1:0] {D_IDLE, D_DELAY, D_ACTIVE} d_state_e;

    u_state_e       u_state_q, u_state_d;
    d_state_e       d_state_q, d_state_d;
    logic           ackout_q, ackout_d;
    logic           cp_q, cp_d;
    logic           drop_q, drop_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] sendout_q, sendout_d;
    logic [DW-1:0]  dataout_q, dataout_d;
    logic [DLYW-1:0] dly_q, dly_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic           push, pop;

    logic [NCH:0]   sync_s;
    logic           sendin_s;
    logic [NCH-1:0] ackin_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sync_s = {SENDIN, ACKIN};
    end else begin : g_sync
        logic [NCH:0] sync_q [SYNC_STAGES];
        // Flop chain resynchronising SENDIN and every ACKIN together
        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
                sync_q[0] <= {SENDIN, ACKIN};
                for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
        end
        assign sync_s = sync_q[SYNC_STAGES-1];
    end

    assign sendin_s = sync_s[NCH];
    assign ackin_s  = sync_s[NCH-1:0];

    // Upstream handshake: capture on request when not full, hold ACKOUT until RTZ
    always_comb begin
        u_state_d = u_state_q;
        ackout_d  = ackout_q;
        push      = 1'b0;
        unique case (u_state_q)
            U_IDLE: begin
                if (sendin_s && (count_q < CW'(DEPTH))) begin
                    push      = 1'b1;
                    ackout_d  = 1'b1;
                    u_state_d = U_ACK;
                end
            end
            U_ACK: begin
                if (!sendin_s) begin
                    ackout_d  = 1'b0;
                    u_state_d = U_IDLE;
                end
            end
            default: u_state_d = U_IDLE;
        endcase
        cp_d = push;
    end

    // Downstream: load head, wait out the delay, then run per-branch four-phase cycles
    always_comb begin
        d_state_d = d_state_q;
        pend_d    = pend_q;
        sendout_d = sendout_q;
        dataout_d = dataout_q;
        dly_d     = dly_q;
        drop_d    = 1'b0;
        pop       = 1'b0;
        unique case (d_state_q)
            D_IDLE: begin
                if (count_q != '0) begin
                    pend_d    = mem_q[rd_ptr_q][DW +: NCH];
                    dataout_d = mem_q[rd_ptr_q][DW-1:0];
                    dly_d     = DLYW'(SEND_DLY);
                    d_state_d = D_DELAY;
                end
            end
            D_DELAY: begin
                if (dly_q != '0) begin
                    dly_d = dly_q - DLYW'(1);
                end else if (LOPEN) begin
                    if (pend_q == '0) begin
                        pop       = 1'b1;
                        drop_d    = 1'b1;
                        d_state_d = D_IDLE;
                    end else begin
                        sendout_d = pend_q;
                        d_state_d = D_ACTIVE;
                    end
                end
            end
            D_ACTIVE: begin
                for (int i = 0; i < NCH; i++) begin
                    if (sendout_q[i] && ackin_s[i]) begin
                        sendout_d[i] = 1'b0;
                    end else if (!sendout_q[i] && pend_q[i] && !ackin_s[i]) begin
                        pend_d[i] = 1'b0;
                    end
                end
                if (pend_d == '0) begin
                    pop       = 1'b1;
                    d_state_d = D_IDLE;
                end
            end
            default: d_state_d = D_IDLE;
        endcase
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            u_state_q <= U_IDLE;
            d_state_q <= D_IDLE;
            ackout_q  <= 1'b0;
            cp_q      <= 1'b0;
            drop_q    <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pend_q    <= '0;
            sendout_q <= '0;
            dataout_q <= '0;
            dly_q     <= '0;
        end else begin
            u_state_q <= u_state_d;
            d_state_q <= d_state_d;
            ackout_q  <= ackout_d;
            cp_q      <= cp_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            sendout_q <= sendout_d;
            dataout_q <= dataout_d;
            dly_q     <= dly_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Token storage: {mask, data} per entry
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {EXBIN, DATAIN};
    end

    assign ACKOUT  = ackout_q;
    assign SENDOUT = sendout_q;
    assign DATAOUT = dataout_q;
    assign CP      = cp_q;
    assign DROP    = drop_q;
    assign COUNT   = count_q;

endmodule

// File: tb/tb_celement_branch_buf.sv
// Directed bench: default instance (SEND_DLY=4, SYNC=2) plus a fast one (SEND_DLY=0, SYNC=0).
module tb_celement_branch_buf;

    logic       CLK;
    logic       RESETN;

    logic       a_lopen, a_sendin, a_ackout, a_cp, a_drop;
    logic [7:0] a_datain, a_dataout;
    logic [1:0] a_exbin, a_sendout, a_ackin;
    logic [2:0] a_count;

    logic       b_lopen, b_sendin, b_ackout, b_cp, b_drop;
    logic [7:0] b_datain, b_dataout;
    logic [1:0] b_exbin, b_sendout, b_ackin;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_pass   = 0;

    celement_branch_buf u_dut (
        .CLK(CLK), .RESETN(RESETN), .LOPEN(a_lopen), .SENDIN(a_sendin),
        .ACKOUT(a_ackout), .DATAIN(a_datain), .EXBIN(a_exbin),
        .SENDOUT(a_sendout), .ACKIN(a_ackin), .DATAOUT(a_dataout),
        .CP(a_cp), .DROP(a_drop), .COUNT(a_count)
    );

    celement_branch_buf #(.SEND_DLY(0), .SYNC_STAGES(0)) u_dut_fast (
        .CLK(CLK), .RESETN(RESETN), .LOPEN(b_lopen), .SENDIN(b_sendin),
        .ACKOUT(b_ackout), .DATAIN(b_datain), .EXBIN(b_exbin),
        .SENDOUT(b_sendout), .ACKIN(b_ackin), .DATAOUT(b_dataout),
        .CP(b_cp), .DROP(b_drop), .COUNT(b_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d, input logic [1:0] m);
        a_datain = d;
        a_exbin  = m;
        a_sendin = 1'b1;
        for (int k = 0; k < 40 && a_ackout !== 1'b1; k++) tick();
        check("push_ack", 32'(a_ackout), 1);
        a_sendin = 1'b0;
        for (int k = 0; k < 40 && a_ackout !== 1'b0; k++) tick();
        check("push_rtz", 32'(a_ackout), 0);
    endtask

    task automatic ack_head_a(input logic [7:0] exp_d, input logic [1:0] m);
        for (int k = 0; k < 60 && a_sendout !== m; k++) tick();
        check("head_req", 32'(a_sendout), 32'(m));
        check("head_data", 32'(a_dataout), 32'(exp_d));
        a_ackin = m;
        for (int k = 0; k < 20 && a_sendout !== 2'b00; k++) tick();
        check("head_clr", 32'(a_sendout), 0);
        a_ackin = 2'b00;
        tick(); tick(); tick();
    endtask

    initial begin
        logic seen;
        RESETN   = 1'b0;
        a_lopen  = 1'b1; a_sendin = 1'b0; a_datain = '0; a_exbin = '0; a_ackin = '0;
        b_lopen  = 1'b1; b_sendin = 1'b0; b_datain = '0; b_exbin = '0; b_ackin = '0;
        tick(); tick();

        // reset state
        check("rst_ackout", 32'(a_ackout), 0);
        check("rst_sendout", 32'(a_sendout), 0);
        check("rst_count", 32'(a_count), 0);
        check("rst_dataout", 32'(a_dataout), 0);
        check("rst_cp_drop", 32'({a_cp, a_drop}), 0);
        RESETN = 1'b1;
        tick(); tick();

        // single token to both branches, staggered acks
        a_datain = 8'hA5; a_exbin = 2'b11; a_sendin = 1'b1;
        tick(); tick();
        check("t1_pre_ack", 32'(a_ackout), 0);
        tick();
        check("t1_cp", 32'(a_cp), 1);
        check("t1_ackout", 32'(a_ackout), 1);
        check("t1_count", 32'(a_count), 1);
        tick();
        check("t1_cp_pulse", 32'(a_cp), 0);
        a_sendin = 1'b0;
        tick(); tick(); tick(); tick();
        check("t1_sendout_early", 32'(a_sendout), 0);
        tick();
        check("t1_sendout", 32'(a_sendout), 32'(2'b11));
        check("t1_dataout", 32'(a_dataout), 32'h A5);
        a_ackin = 2'b01;
        tick(); tick(); tick();
        check("t1_br0_clr", 32'(a_sendout), 32'(2'b10));
        a_ackin = 2'b00;
        tick(); tick();
        a_ackin = 2'b10;
        tick(); tick(); tick();
        check("t1_br1_clr", 32'(a_sendout), 0);
        check("t1_no_pop", 32'(a_count), 1);
        a_ackin = 2'b00;
        tick(); tick();
        check("t1_pre_pop", 32'(a_count), 1);
        tick();
        check("t1_pop", 32'(a_count), 0);
        tick(); tick(); tick();

        // all-zero mask token is dropped after the delay
        a_datain = 8'h3C; a_exbin = 2'b00; a_sendin = 1'b1;
        tick(); tick(); tick();
        check("t2_count", 32'(a_count), 1);
        tick();
        a_sendin = 1'b0;
        tick(); tick(); tick(); tick();
        check("t2_drop_early", 32'(a_drop), 0);
        tick();
        check("t2_drop", 32'(a_drop), 1);
        check("t2_count0", 32'(a_count), 0);
        check("t2_no_send", 32'(a_sendout), 0);
        tick();
        check("t2_drop_pulse", 32'(a_drop), 0);
        tick(); tick(); tick();

        // five tokens into a four-deep FIFO
        for (int t = 1; t <= 4; t++) push_a(8'(t), 2'b01);
        check("t3_full", 32'(a_count), 4);
        a_datain = 8'h05; a_exbin = 2'b01; a_sendin = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("t3_held_off", 32'(a_ackout), 0);
        check("t3_full_hold", 32'(a_count), 4);
        ack_head_a(8'h01, 2'b01);
        for (int k = 0; k < 20 && a_ackout !== 1'b1; k++) tick();
        check("t3_fifth_ack", 32'(a_ackout), 1);
        a_sendin = 1'b0;
        for (int k = 0; k < 20 && a_ackout !== 1'b0; k++) tick();
        for (int t = 2; t <= 5; t++) ack_head_a(8'(t), 2'b01);
        check("t3_drained", 32'(a_count), 0);

        // LOPEN gating
        a_lopen = 1'b0;
        push_a(8'h11, 2'b11);
        for (int k = 0; k < 30; k++) tick();
        check("t4_gated", 32'(a_sendout), 0);
        check("t4_count", 32'(a_count), 1);
        a_lopen = 1'b1;
        tick();
        check("t4_open", 32'(a_sendout), 32'(2'b11));
        a_lopen = 1'b0;
        a_ackin = 2'b01;
        for (int k = 0; k < 20 && a_sendout !== 2'b10; k++) tick();
        a_ackin = 2'b00;
        for (int k = 0; k < 5; k++) tick();
        check("t4_held_high", 32'(a_sendout), 32'(2'b10));
        a_ackin = 2'b10;
        for (int k = 0; k < 20 && a_sendout !== 2'b00; k++) tick();
        a_ackin = 2'b00;
        for (int k = 0; k < 20 && a_count !== 3'd0; k++) tick();
        check("t4_pop", 32'(a_count), 0);
        a_lopen = 1'b1;
        tick(); tick();

        // capture and pop in the same cycle at COUNT=2
        push_a(8'h21, 2'b01);
        push_a(8'h22, 2'b01);
        for (int k = 0; k < 60 && a_sendout !== 2'b01; k++) tick();
        check("t5_head", 32'(a_dataout), 32'h21);
        a_ackin = 2'b01;
        for (int k = 0; k < 20 && a_sendout !== 2'b00; k++) tick();
        a_ackin  = 2'b00;
        a_datain = 8'h23; a_exbin = 2'b01; a_sendin = 1'b1;
        tick(); tick();
        check("t5_before", 32'(a_count), 2);
        tick();
        check("t5_same_cycle", 32'(a_count), 2);
        check("t5_cp", 32'(a_cp), 1);
        a_sendin = 1'b0;
        for (int k = 0; k < 20 && a_ackout !== 1'b0; k++) tick();
        ack_head_a(8'h22, 2'b01);
        ack_head_a(8'h23, 2'b01);
        check("t5_drained", 32'(a_count), 0);

        // reset mid-handshake
        push_a(8'h44, 2'b01);
        for (int k = 0; k < 60 && a_sendout !== 2'b01; k++) tick();
        check("t6_pre_rst", 32'(a_sendout), 32'(2'b01));
        #2 RESETN = 1'b0;
        #1;
        check("t6_rst_sendout", 32'(a_sendout), 0);
        check("t6_rst_count", 32'(a_count), 0);
        check("t6_rst_misc", 32'({a_ackout, a_cp, a_drop, a_dataout}), 0);
        a_ackin = 2'b00;
        tick(); tick();
        RESETN = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (a_sendout !== 2'b00) seen = 1'b1;
        end
        check("t6_no_resend", 32'(seen), 0);
        check("t6_count", 32'(a_count), 0);

        // fast instance: minimum latency and spurious branch ack
        b_datain = 8'h5A; b_exbin = 2'b01; b_sendin = 1'b1;
        tick();
        check("t7_cp", 32'(b_cp), 1);
        tick();
        check("t7_sendout_early", 32'(b_sendout), 0);
        b_sendin = 1'b0;
        tick();
        check("t7_sendout", 32'(b_sendout), 32'(2'b01));
        check("t7_dataout", 32'(b_dataout), 32'h5A);
        b_ackin = 2'b10;
        tick(); tick(); tick();
        check("t7_spurious", 32'(b_sendout), 32'(2'b01));
        check("t7_spur_count", 32'(b_count), 1);
        b_ackin = 2'b01;
        tick();
        check("t7_clr", 32'(b_sendout), 0);
        b_ackin = 2'b00;
        tick();
        check("t7_pop", 32'(b_count), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
